// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   state_t  : read-return tracking state of the arbiter FSM
//   owner_t  : which requester (if any) drives the RAM this cycle
//   WAIT_W   : width of the external-port starvation counter
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CPU_RD = 2'd1,
        S_EXT_RD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve
// Saturating starvation counter for the external RAM port. Counts cycles in
// which the external side waits without being granted; once it reaches
// MAX_WAIT the external port gets priority over the CPU.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   ext_valid   : external request pending
//   ext_issued  : external request granted this cycle
//   ext_pri     : external port has priority this cycle
// ---------------------------------------------------------------------------
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_valid,
    input  logic ext_issued,
    output logic ext_pri
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    // Any grant or a dropped request restarts the count; otherwise count up
    // while waiting and hold at MAX_CNT until the grant arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (ext_issued || !ext_valid) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign ext_pri = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port synchronous data RAM between the CPU MEM stage and
// an external requester (loader / debug). CPU has fixed priority, but the
// external port is guaranteed a slot after MAX_WAIT lost cycles. The RAM's
// one-cycle read latency is absorbed by stalling the pipeline.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_rdata   : MEM-stage access, load data return
//   cpu_stall                          : hold pipeline up to and including MEM
//   ext_valid/we/addr/wdata            : external request (held until ready)
//   ext_ready, ext_rvalid, ext_rdata   : accept, read-return pulse, read data
//   mem_ce/we/addr/wdata, mem_rdata    : RAM macro interface
//   stat_stall_cnt, stat_ext_cnt       : stall-cycle / external-issue counters
// Configuration:
//   DMEM_ARB_STATS_EN defined builds the statistics counters; otherwise the
//   stat ports are tied to zero.
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_valid,
    input  logic          ext_we,
    input  logic [31:0]   ext_addr,
    input  logic [31:0]   ext_wdata,
    output logic          ext_ready,
    output logic          ext_rvalid,
    output logic [31:0]   ext_rdata,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   stat_stall_cnt,
    output logic [31:0]   stat_ext_cnt
);

    state_t state;
    state_t next_state;
    owner_t owner;
    logic   ext_pri;
    logic   cpu_ok;
    logic   cpu_issued;
    logic   ext_issued;
    logic   unused_addr_bits;

    // Word addressing only: byte-lane and high address bits are ignored.
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                                ext_addr[31:AW+2], ext_addr[1:0]};

    dmem_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_valid  (ext_valid),
        .ext_issued (ext_issued),
        .ext_pri    (ext_pri)
    );

    // A CPU load in S_CPU_RD is completing this cycle, so it must not be
    // reissued; that frees the slot for the external port.
    assign cpu_ok = cpu_req && (state != S_CPU_RD);

    always_comb begin
        owner = OWN_NONE;
        if (ext_valid && (ext_pri || !cpu_ok)) begin
            owner = OWN_EXT;
        end else if (cpu_ok) begin
            owner = OWN_CPU;
        end
    end

    assign ext_issued = (owner == OWN_EXT);
    assign cpu_issued = (owner == OWN_CPU);

    // RAM mux and read-return tracking. Reads from either side may issue in
    // any state because the RAM is pipelined.
    always_comb begin
        next_state = S_IDLE;
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (owner)
            OWN_CPU: begin
                mem_ce    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr[AW+1:2];
                mem_wdata = cpu_wdata;
                if (!cpu_we) begin
                    next_state = S_CPU_RD;
                end
            end
            OWN_EXT: begin
                mem_ce    = 1'b1;
                mem_we    = ext_we;
                mem_addr  = ext_addr[AW+1:2];
                mem_wdata = ext_wdata;
                if (!ext_we) begin
                    next_state = S_EXT_RD;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A granted store completes immediately; a load (or a lost request)
    // holds the pipeline until its data returns in S_CPU_RD.
    assign cpu_stall = cpu_req && (state != S_CPU_RD) && (!cpu_issued || !cpu_we);

    // Returning read data is suppressed while reset is asserted so that an
    // outstanding read is discarded rather than delivered.
    assign ext_ready  = ext_issued;
    assign ext_rvalid = rst_n && (state == S_EXT_RD);
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;
    assign cpu_rdata  = (rst_n && (state == S_CPU_RD)) ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_stall_cnt <= '0;
            stat_ext_cnt   <= '0;
        end else begin
            if (cpu_stall) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (ext_issued) begin
                stat_ext_cnt <= stat_ext_cnt + 32'd1;
            end
        end
    end
`else
    assign stat_stall_cnt = '0;
    assign stat_ext_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural one-cycle-latency RAM.
// Inputs change on the falling edge; outputs are checked 1 ns later, well
// away from the rising edge where the DUT and RAM update.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW       = 14;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          ext_valid;
    logic          ext_we;
    logic [31:0]   ext_addr;
    logic [31:0]   ext_wdata;
    logic          ext_ready;
    logic          ext_rvalid;
    logic [31:0]   ext_rdata;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   stat_stall_cnt;
    logic [31:0]   stat_ext_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] ram [0:(1<<AW)-1];

    dmem_arbiter #(
        .AW       (AW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .ext_valid      (ext_valid),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_ready      (ext_ready),
        .ext_rvalid     (ext_rvalid),
        .ext_rdata      (ext_rdata),
        .mem_ce         (mem_ce),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_ext_cnt   (stat_ext_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM: read data appears one cycle after issue.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rst, input logic creq, input logic cwe,
                                 input logic [31:0] caddr, input logic [31:0] cdata,
                                 input logic evld, input logic ewe,
                                 input logic [31:0] eaddr, input logic [31:0] edata);
        @(negedge clk);
        rst_n     = rst;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cdata;
        ext_valid = evld;
        ext_we    = ewe;
        ext_addr  = eaddr;
        ext_wdata = edata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_cnt++;
        assert (observed === expected) else begin
            err_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ext_valid = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_state",  32'(dut.state), 32'(S_IDLE));
        checkOutput("rst_wait",   32'(dut.u_starve.wait_cnt), 0);
        checkOutput("rst_stall",  32'(cpu_stall), 0);
        checkOutput("rst_rvalid", 32'(ext_rvalid), 0);
        checkOutput("rst_cpurd",  cpu_rdata, 0);
        checkOutput("rst_ce",     32'(mem_ce), 0);
        checkOutput("rst_sstat",  stat_stall_cnt, 0);
        checkOutput("rst_estat",  stat_ext_cnt, 0);

        // CPU store 0xDEADBEEF to byte 0x10 (word 4): no stall
        applyStimulus(1, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
        checkOutput("st_ce",    32'(mem_ce), 1);
        checkOutput("st_we",    32'(mem_we), 1);
        checkOutput("st_addr",  32'(mem_addr), 4);
        checkOutput("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        checkOutput("st_stall", 32'(cpu_stall), 0);

        // CPU load from 0x10: one stall cycle, then the data
        applyStimulus(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("ld_stall", 32'(cpu_stall), 1);
        checkOutput("ld_we",    32'(mem_we), 0);
        checkOutput("ld_ce",    32'(mem_ce), 1);
        applyStimulus(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("ld_stall2", 32'(cpu_stall), 0);
        checkOutput("ld_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        checkOutput("ld_ce2",    32'(mem_ce), 0);

        // CPU store 0x1234 to 0x20, then external read of it
        applyStimulus(1, 1, 1, 32'h20, 32'h1234, 0, 0, 0, 0);
        checkOutput("st2_stall", 32'(cpu_stall), 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
        checkOutput("er_ready", 32'(ext_ready), 1);
        checkOutput("er_addr",  32'(mem_addr), 8);
        checkOutput("er_rv0",   32'(ext_rvalid), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("er_rvalid", 32'(ext_rvalid), 1);
        checkOutput("er_rdata",  ext_rdata, 32'h1234);
        checkOutput("er_ready2", 32'(ext_ready), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("er_rvoff", 32'(ext_rvalid), 0);
        checkOutput("er_rdoff", ext_rdata, 0);

        // Contention: CPU stores every cycle, external write waits MAX_WAIT
        for (int i = 0; i <= MAX_WAIT; i++) begin
            applyStimulus(1, 1, 1, 32'h100, 32'hAAAA_0000, 1, 1, 32'h40, 32'hCAFE);
            checkOutput("ct_wait",  32'(dut.u_starve.wait_cnt), 32'(i));
            checkOutput("ct_ready", 32'(ext_ready), 32'(i == MAX_WAIT));
            checkOutput("ct_stall", 32'(cpu_stall), 32'(i == MAX_WAIT));
        end
        checkOutput("ct_eaddr", 32'(mem_addr), 32'h10);
        checkOutput("ct_ewd",   mem_wdata, 32'hCAFE);
        applyStimulus(1, 1, 1, 32'h100, 32'hAAAA_0000, 0, 0, 0, 0);
        checkOutput("ct_wait0", 32'(dut.u_starve.wait_cnt), 0);
        checkOutput("ct_stl0",  32'(cpu_stall), 0);
        checkOutput("ct_caddr", 32'(mem_addr), 32'h40);
        // External write landed: read it back
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h40, 0);
        checkOutput("cw_ready", 32'(ext_ready), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("cw_rdata", ext_rdata, 32'hCAFE);

        // CPU load, then external read issued in the S_CPU_RD cycle
        applyStimulus(1, 1, 0, 32'h20, 0, 0, 0, 0, 0);
        checkOutput("bb_stall", 32'(cpu_stall), 1);
        applyStimulus(1, 1, 0, 32'h20, 0, 1, 0, 32'h10, 0);
        checkOutput("bb_state", 32'(dut.state), 32'(S_CPU_RD));
        checkOutput("bb_cpurd", cpu_rdata, 32'h1234);
        checkOutput("bb_stl0",  32'(cpu_stall), 0);
        checkOutput("bb_ready", 32'(ext_ready), 1);
        checkOutput("bb_addr",  32'(mem_addr), 4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("bb_rvalid", 32'(ext_rvalid), 1);
        checkOutput("bb_rdata",  ext_rdata, 32'hDEAD_BEEF);
        checkOutput("bb_cpurd0", cpu_rdata, 0);

        // Reset while an external read is returning: no pulse delivered
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
        checkOutput("rr_ready", 32'(ext_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rr_state", 32'(dut.state), 32'(S_EXT_RD));
        checkOutput("rr_rvalid", 32'(ext_rvalid), 0);
        checkOutput("rr_rdata",  ext_rdata, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rr_idle",   32'(dut.state), 32'(S_IDLE));
        checkOutput("rr_rv2",    32'(ext_rvalid), 0);
        checkOutput("rr_sstat",  stat_stall_cnt, 0);
        checkOutput("rr_estat",  stat_ext_cnt, 0);

        // Reset clears a partially accumulated starvation count
        applyStimulus(1, 1, 1, 32'h100, 32'h1, 1, 1, 32'h44, 32'h2);
        checkOutput("rw_wait0", 32'(dut.u_starve.wait_cnt), 0);
        applyStimulus(1, 1, 1, 32'h100, 32'h1, 1, 1, 32'h44, 32'h2);
        checkOutput("rw_wait1", 32'(dut.u_starve.wait_cnt), 1);
        applyStimulus(0, 1, 1, 32'h100, 32'h1, 1, 1, 32'h44, 32'h2);
        checkOutput("rw_wait2", 32'(dut.u_starve.wait_cnt), 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rw_waitr", 32'(dut.u_starve.wait_cnt), 0);
        checkOutput("rw_state", 32'(dut.state), 32'(S_IDLE));
        checkOutput("rw_sstat", stat_stall_cnt, 0);
        checkOutput("rw_estat", stat_ext_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
